// File: rtl/vliw_fetch_unit.sv
// rtl/vliw_fetch_unit.sv - VLIW instruction fetch stage with PC, imem request tracking and prefetch FIFO
//
// Ports:
//   clk, reset                     : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt    : bundle fetch request to instruction memory (addr = pc)
//   imem_rvalid/imem_rdata         : in-order bundle responses
//   redirect/redirect_target       : branch/jump redirect, flushes and refetches
//   halt                           : level-sensitive, blocks new requests
//   id_stall                       : IF/ID not accepting this cycle
//   fetch_valid/fetch_word/fetch_pc: FIFO head presented to IF/ID
//   ifid_write                     : IF/ID write enable (fetch_valid && !id_stall)
module vliw_fetch_unit #(
    parameter int          BUF_DEPTH       = 2,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    input  logic        halt,
    input  logic        id_stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_word,
    output logic [31:0] fetch_pc,
    output logic        ifid_write
);
    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_count;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [31:0]   r_word [BUF_DEPTH];
    logic [31:0]   r_wpc  [BUF_DEPTH];

    logic w_can_issue;
    logic w_accept;
    logic w_push;
    logic w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Reserving FIFO space for every outstanding request means a response
    // always has somewhere to land; stale requests are counted too.
    assign w_can_issue = (int'(r_outstanding) < MAX_OUTSTANDING) &&
                         ((int'(r_count) + int'(r_outstanding)) < BUF_DEPTH);

    // Gated by reset so the request drops the instant reset asserts.
    assign imem_req    = reset && !halt && !redirect && w_can_issue;
    assign imem_addr   = r_pc;
    assign w_accept    = imem_req && imem_gnt;

    assign fetch_valid = (r_count != '0) && !redirect;
    assign fetch_word  = r_word[r_rd_ptr];
    assign fetch_pc    = r_wpc[r_rd_ptr];
    assign ifid_write  = fetch_valid && !id_stall;

    // Responses owed to pre-redirect requests are swallowed via r_drop_cnt.
    assign w_push      = imem_rvalid && !redirect && (r_drop_cnt == '0);
    assign w_pop       = ifid_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= RESET_PC;
            r_resp_pc     <= RESET_PC;
            r_count       <= '0;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_word[i] <= '0;
                r_wpc[i]  <= '0;
            end
        end else begin
            case ({w_accept, imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase

            if (redirect) begin
                r_pc       <= redirect_target;
                r_resp_pc  <= redirect_target;
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                // Everything still in flight after this cycle is stale,
                // including requests already marked for dropping.
                r_drop_cnt <= r_outstanding - OW'(imem_rvalid);
            end else begin
                if (w_accept) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (imem_rvalid && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - OW'(1);
                end
                if (w_push) begin
                    r_word[r_wr_ptr] <= imem_rdata;
                    r_wpc[r_wr_ptr]  <= r_resp_pc;
                    r_wr_ptr         <= ptr_inc(r_wr_ptr);
                    r_resp_pc        <= r_resp_pc + 32'd4;
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vliw_fetch_unit.sv
// tb/tb_vliw_fetch_unit.sv - self-checking bench for vliw_fetch_unit
module tb_vliw_fetch_unit;
    localparam int          DEPTH = 2;
    localparam int          MAXO  = 2;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        halt = 1'b0;
    logic        id_stall = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_word;
    logic [31:0] fetch_pc;
    logic        ifid_write;

    vliw_fetch_unit #(
        .BUF_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_target(redirect_target),
        .halt(halt), .id_stall(id_stall),
        .fetch_valid(fetch_valid), .fetch_word(fetch_word), .fetch_pc(fetch_pc),
        .ifid_write(ifid_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] maddr;
        int          due;
        bit          stale;
    } req_t;

    req_t        q[$];
    logic [31:0] bufq[$];
    logic [31:0] exp_issue = RPC;
    int          cyc = 0;
    int          lat = 1;
    logic        nxt_rvalid = 1'b0;
    logic [31:0] nxt_rdata = '0;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] bundle(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outstanding requests as a queue of tags, the buffer as
    // a queue of PCs; a redirect marks every pending tag stale.
    always @(negedge clk) begin
        logic exp_req;
        logic exp_fv;
        logic acc;
        req_t e;
        if (!reset) begin
            check("rst_imem_req",    {31'b0, imem_req},    32'd0);
            check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
            check("rst_ifid_write",  {31'b0, ifid_write},  32'd0);
            check("rst_fetch_word",  fetch_word,           32'd0);
            check("rst_fetch_pc",    fetch_pc,             32'd0);
            q.delete();
            bufq.delete();
            exp_issue = RPC;
        end else begin
            exp_req = !halt && !redirect && (q.size() < MAXO) && ((q.size() + bufq.size()) < DEPTH);
            exp_fv  = (bufq.size() > 0) && !redirect;
            check("imem_req",    {31'b0, imem_req},    {31'b0, exp_req});
            check("imem_addr",   imem_addr,            exp_issue);
            check("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_fv});
            check("ifid_write",  {31'b0, ifid_write},  {31'b0, exp_fv && !id_stall});
            if (exp_fv) begin
                check("fetch_pc",   fetch_pc,   bufq[0]);
                check("fetch_word", fetch_word, bundle(bufq[0]));
            end
            acc = exp_req && imem_gnt;
            if (exp_fv && !id_stall) void'(bufq.pop_front());
            if (imem_rvalid && q.size() > 0) begin
                e = q.pop_front();
                if (!redirect && !e.stale) bufq.push_back(e.pc);
            end
            if (redirect) begin
                bufq.delete();
                foreach (q[i]) q[i].stale = 1'b1;
                exp_issue = redirect_target;
            end
            if (acc) begin
                e.pc = exp_issue; e.maddr = imem_addr; e.due = cyc + lat; e.stale = 1'b0;
                q.push_back(e);
                exp_issue = exp_issue + 32'd4;
            end
        end
        cyc++;
        nxt_rvalid = (q.size() > 0) && (q[0].due <= cyc);
        nxt_rdata  = nxt_rvalid ? bundle(q[0].maddr) : 32'd0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        imem_rvalid = nxt_rvalid;
        imem_rdata  = nxt_rdata;
    endtask

    task automatic drain();
        halt = 1'b1;
        id_stall = 1'b0;
        repeat (10) tick();
    endtask

    initial begin
        int n_pop;
        int n_req;
        bit seen;

        // Phase 1: reset and zero-wait streaming
        repeat (3) tick();
        reset = 1'b1;
        @(negedge clk);
        check("p1_first_req",  {31'b0, imem_req}, 32'd1);
        check("p1_first_addr", imem_addr, 32'h100);
        tick();
        @(negedge clk);
        check("p1_c1_valid", {31'b0, fetch_valid}, 32'd0);
        check("p1_c1_addr",  imem_addr, 32'h104);
        tick();
        @(negedge clk);
        check("p1_c2_valid", {31'b0, fetch_valid}, 32'd1);
        check("p1_c2_pc",    fetch_pc,   32'h100);
        check("p1_c2_word",  fetch_word, 32'hFEFF_0100);
        repeat (6) tick();
        imem_gnt = 1'b0;
        repeat (2) tick();
        imem_gnt = 1'b1;
        repeat (6) tick();

        // Phase 2: stall from reset fills exactly two bundles
        reset = 1'b0;
        repeat (2) tick();
        id_stall = 1'b1;
        reset = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("p2_req_blocked", {31'b0, imem_req}, 32'd0);
        check("p2_head_pc",     fetch_pc,   32'h100);
        check("p2_head_word",   fetch_word, 32'hFEFF_0100);
        tick();
        id_stall = 1'b0;
        @(negedge clk);
        check("p2_rel_pc0", fetch_pc, 32'h100);
        check("p2_rel_wr0", {31'b0, ifid_write}, 32'd1);
        tick();
        @(negedge clk);
        check("p2_rel_pc1",   fetch_pc,   32'h104);
        check("p2_rel_word1", fetch_word, 32'hFEFB_0104);
        repeat (4) tick();

        // Phase 3: latency 3, redirect before first response
        drain();
        lat = 3;
        halt = 1'b0;
        redirect = 1'b1; redirect_target = 32'h200;
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("p3_a0_addr", imem_addr, 32'h200);
        tick();
        @(negedge clk);
        check("p3_a1_addr", imem_addr, 32'h204);
        check("p3_a1_req",  {31'b0, imem_req}, 32'd1);
        tick();
        redirect = 1'b1; redirect_target = 32'h400;
        @(negedge clk);
        check("p3_rd_req", {31'b0, imem_req}, 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("p3_next_addr", imem_addr, 32'h400);
        check("p3_a3_valid",  {31'b0, fetch_valid}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            @(negedge clk);
            if (fetch_valid) begin
                seen = 1'b1;
                check("p3_first_pc", fetch_pc, 32'h400);
            end
        end
        if (!seen) check("p3_valid_timeout", 32'd0, 32'd1);
        repeat (4) tick();

        // Phase 4: redirect coincident with the only response
        drain();
        lat = 1;
        halt = 1'b0;
        tick();
        @(negedge clk);
        check("p4_b0_req", {31'b0, imem_req}, 32'd1);
        tick();
        redirect = 1'b1; redirect_target = 32'h800;
        @(negedge clk);
        check("p4_b1_rvalid_seen", {31'b0, imem_rvalid}, 32'd1);
        check("p4_b1_valid",       {31'b0, fetch_valid}, 32'd0);
        check("p4_b1_req",         {31'b0, imem_req},    32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        check("p4_b2_req",   {31'b0, imem_req}, 32'd1);
        check("p4_b2_addr",  imem_addr, 32'h800);
        check("p4_b2_valid", {31'b0, fetch_valid}, 32'd0);
        repeat (6) tick();

        // Phase 5: halt with two outstanding
        drain();
        lat = 3;
        halt = 1'b0;
        redirect = 1'b1; redirect_target = 32'hA00;
        tick();
        redirect = 1'b0;
        repeat (2) tick();
        halt = 1'b1;
        n_pop = 0; n_req = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ifid_write) n_pop++;
            if (imem_req) n_req++;
            tick();
        end
        check("p5_halt_pops", n_pop, 32'd2);
        check("p5_halt_reqs", n_req, 32'd0);
        halt = 1'b0;
        @(negedge clk);
        check("p5_resume_req",  {31'b0, imem_req}, 32'd1);
        check("p5_resume_addr", imem_addr, 32'hA08);
        repeat (8) tick();

        // Phase 6: async reset with a full FIFO
        lat = 1;
        id_stall = 1'b1;
        repeat (6) tick();
        @(negedge clk);
        check("p6_full_valid", {31'b0, fetch_valid}, 32'd1);
        check("p6_full_req",   {31'b0, imem_req},    32'd0);
        tick();
        #2;
        reset = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        check("p6_async_req",   {31'b0, imem_req},    32'd0);
        check("p6_async_valid", {31'b0, fetch_valid}, 32'd0);
        check("p6_async_wr",    {31'b0, ifid_write},  32'd0);
        check("p6_async_word",  fetch_word, 32'd0);
        check("p6_async_pc",    fetch_pc,   32'd0);
        repeat (2) tick();
        reset = 1'b1;
        id_stall = 1'b0;
        @(negedge clk);
        check("p6_restart_req",  {31'b0, imem_req}, 32'd1);
        check("p6_restart_addr", imem_addr, 32'h100);
        repeat (10) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
